// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared types and constants for the serial frame transmitter
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        PAR
    } sftx_state_t;

    localparam logic [3:0] DEFAULT_PREAMBLE = 4'b1011;

endpackage

// File: rtl/serial_frame_tx_piso.sv
// rtl/serial_frame_tx_piso.sv - parallel-load, shift-left register exposing its msb
module piso_shreg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] d,
    output logic              msb
);

    logic [DATA_W-1:0] q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= q << 1;
        end
    end

    assign msb = q[DATA_W-1];

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - serial frame transmitter: preamble, MSB-first payload, optional even parity
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter int               PRE_W     = 4,
    parameter logic [PRE_W-1:0] PREAMBLE  = DEFAULT_PREAMBLE,
    parameter int               PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sd,
    output logic              busy,
    output logic              done
);

    localparam int MAX_W = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    sftx_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             par;
    logic             accept;
    logic             shift;
    logic             msb;

    function automatic logic pre_bit(input int idx);
        pre_bit = 1'b0;
        for (int i = 0; i < PRE_W; i++) begin
            if (i == idx) pre_bit = PREAMBLE[i];
        end
    endfunction

    // done is registered alongside sd, so it marks the final bit currently on the line
    assign din_ready = (state == IDLE) || done;
    assign accept    = din_valid && din_ready;

    // the register shifts whenever the next bit put on sd is a payload bit
    assign shift = ((state == PRE)  && (int'(cnt) == PRE_W - 1)) ||
                   ((state == DATA) && (int'(cnt) != DATA_W - 1));

    piso_shreg #(.DATA_W(DATA_W)) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift),
        .d     (din),
        .msb   (msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            par   <= 1'b0;
            sd    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state <= PRE;
                cnt   <= '0;
                par   <= ^din;
                sd    <= PREAMBLE[PRE_W-1];
                busy  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        sd   <= 1'b0;
                        busy <= 1'b0;
                    end
                    PRE: begin
                        if (int'(cnt) == PRE_W - 1) begin
                            state <= DATA;
                            cnt   <= '0;
                            sd    <= msb;
                            done  <= (DATA_W == 1) && (PARITY_EN == 0);
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                            sd  <= pre_bit(PRE_W - 2 - int'(cnt));
                        end
                    end
                    DATA: begin
                        if (int'(cnt) == DATA_W - 1) begin
                            if (PARITY_EN != 0) begin
                                state <= PAR;
                                sd    <= par;
                                done  <= 1'b1;
                            end else begin
                                state <= IDLE;
                                sd    <= 1'b0;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt  <= cnt + CNT_W'(1);
                            sd   <= msb;
                            done <= (PARITY_EN == 0) && (int'(cnt) + 2 == DATA_W);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        sd    <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
